// File: rtl/intack_sequencer.sv
// Interrupt-acknowledge initiator for the 8259 PIC: drives the int_ack pulse train and returns the vector.
// Define INTACK_8080_MODE_EN to add the 3-pulse MCS-80 sequence (mode_8080 / opcode_err ports).
module intack_sequencer #(
   parameter int PULSE_WIDTH = 2,
   parameter int GAP_WIDTH   = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        INT,
   input  logic        cpu_int_enable,
   input  logic [7:0]  data_bus,
`ifdef INTACK_8080_MODE_EN
   input  logic        mode_8080,
   output logic        opcode_err,
`endif
   output logic        int_ack,
   output logic        busy,
   output logic [15:0] vector,
   output logic        vector_valid,
   input  logic        vector_ready
);

   localparam logic [3:0] PW_LD       = 4'(PULSE_WIDTH - 1);
   localparam logic [3:0] GW_LD       = 4'(GAP_WIDTH - 1);
   localparam logic [7:0] CALL_OPCODE = 8'hCD;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACK1 = 3'd1,
      GAP1 = 3'd2,
      ACK2 = 3'd3,
`ifdef INTACK_8080_MODE_EN
      GAP2 = 3'd4,
      ACK3 = 3'd5,
`endif
      DONE = 3'd6
   } state_t;

   state_t     state_q, state_nxt;
   logic [3:0] cnt_q, cnt_nxt;
   logic       fin;
`ifdef INTACK_8080_MODE_EN
   logic       mode_q, mode_nxt;
   logic       cap_b1, cap_b2;
   logic [7:0] b1_q, b2_q;
`endif

   function automatic logic is_ack(input state_t s);
      is_ack = (s == ACK1) || (s == ACK2);
`ifdef INTACK_8080_MODE_EN
      is_ack = is_ack || (s == ACK3);
`endif
   endfunction

   // next-state: each ACK/GAP phase runs until its down-counter hits zero
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      fin       = 1'b0;
`ifdef INTACK_8080_MODE_EN
      mode_nxt  = mode_q;
      cap_b1    = 1'b0;
      cap_b2    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (INT && cpu_int_enable) begin
               state_nxt = ACK1;
               cnt_nxt   = PW_LD;
`ifdef INTACK_8080_MODE_EN
               mode_nxt  = mode_8080;
`endif
            end
         end
         ACK1: begin
            if (cnt_q == 4'd0) begin
               state_nxt = GAP1;
               cnt_nxt   = GW_LD;
`ifdef INTACK_8080_MODE_EN
               cap_b1    = 1'b1;
`endif
            end else begin
               cnt_nxt = cnt_q - 4'd1;
            end
         end
         GAP1: begin
            if (cnt_q == 4'd0) begin
               state_nxt = ACK2;
               cnt_nxt   = PW_LD;
            end else begin
               cnt_nxt = cnt_q - 4'd1;
            end
         end
         ACK2: begin
            if (cnt_q == 4'd0) begin
`ifdef INTACK_8080_MODE_EN
               if (mode_q) begin
                  state_nxt = GAP2;
                  cnt_nxt   = GW_LD;
                  cap_b2    = 1'b1;
               end else begin
                  state_nxt = DONE;
                  fin       = 1'b1;
               end
`else
               state_nxt = DONE;
               fin       = 1'b1;
`endif
            end else begin
               cnt_nxt = cnt_q - 4'd1;
            end
         end
`ifdef INTACK_8080_MODE_EN
         GAP2: begin
            if (cnt_q == 4'd0) begin
               state_nxt = ACK3;
               cnt_nxt   = PW_LD;
            end else begin
               cnt_nxt = cnt_q - 4'd1;
            end
         end
         ACK3: begin
            if (cnt_q == 4'd0) begin
               state_nxt = DONE;
               fin       = 1'b1;
            end else begin
               cnt_nxt = cnt_q - 4'd1;
            end
         end
`endif
         DONE: begin
            if (vector_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state register; outputs are flopped from the next state so none is combinational
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         int_ack      <= 1'b0;
         busy         <= 1'b0;
         vector_valid <= 1'b0;
         vector       <= 16'h0000;
`ifdef INTACK_8080_MODE_EN
         mode_q       <= 1'b0;
         opcode_err   <= 1'b0;
`endif
      end else begin
         state_q      <= state_nxt;
         cnt_q        <= cnt_nxt;
         int_ack      <= is_ack(state_nxt);
         busy         <= (state_nxt != IDLE);
         vector_valid <= (state_nxt == DONE);
`ifdef INTACK_8080_MODE_EN
         mode_q       <= mode_nxt;
         if (fin) begin
            vector     <= mode_q ? {data_bus, b2_q} : {8'h00, data_bus};
            opcode_err <= mode_q && (b1_q != CALL_OPCODE);
         end
`else
         if (fin) begin
            vector <= {8'h00, data_bus};
         end
`endif
      end
   end

`ifdef INTACK_8080_MODE_EN
   // intermediate bytes never reach an output directly, so they need no reset
   always_ff @(posedge clk) begin
      if (cap_b1) b1_q <= data_bus;
      if (cap_b2) b2_q <= data_bus;
   end
`endif

endmodule

// File: doc/intack_sequencer.md
# intack_sequencer

CPU-side interrupt-acknowledge initiator for the 8259 PIC subsystem. It watches the PIC's `INT` output and, when interrupts are enabled, drives the `int_ack` pulse train that the PIC control logic responds to. It samples the bytes the PIC places on the data bus and presents the resulting vector to the core through a valid/ready handshake. It replaces ad-hoc bench stimulus and serves as the acknowledge master in system-level integration.

## Interface
Parameters:
- `PULSE_WIDTH`, default 2: number of clock cycles `int_ack` stays high per pulse (legal 1–15).
- `GAP_WIDTH`, default 2: number of clock cycles `int_ack` stays low between pulses (legal 1–15).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: sole clock; all state changes on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `INT`  in  1: interrupt request from the PIC, active high.
- `cpu_int_enable`  in  1: CPU interrupt-enable flag (IF); gates the start of a sequence only.
- `data_bus`  in  8: byte driven by the PIC during acknowledge.
- `int_ack`  out  1: acknowledge pulse to the PIC, active high.
- `busy`  out  1: high in every state except IDLE.
- `vector`  out  16: captured vector, valid only while `vector_valid` is high.
- `vector_valid`  out  1: vector available.
- `vector_ready`  in  1: core accepts the vector.
- `opcode_err`  out  1: 8080 first byte was not 8'hCD. Qualified by `vector_valid`. Present only with the macro.
- `mode_8080`  in  1: 1 selects the 3-pulse MCS-80 sequence. Present only with the macro.

## Operation
- Reset values: `int_ack`=0, `busy`=0, `vector`=16'h0000, `vector_valid`=0, `opcode_err`=0. The FSM is in IDLE and the counter is 0.
- States: IDLE, ACK1, GAP1, ACK2, GAP2, ACK3, DONE. GAP2 and ACK3 exist only with the macro.
- IDLE → ACK1 when `INT & cpu_int_enable` is sampled high.
- Each ACKn state lasts `PULSE_WIDTH` cycles with `int_ack`=1.
- Each GAPn state lasts `GAP_WIDTH` cycles with `int_ack`=0.
- A 4-bit down-counter is loaded on entry to each ACKn/GAPn state; the state advances when the counter reaches 0.
- Sequence in 8086 mode (N=2 pulses): ACK1 → GAP1 → ACK2 → DONE.
  - The byte from pulse 1 is ignored.
  - `vector` = {8'h00, byte2}.
- Sequence in 8080 mode (N=3 pulses): ACK1 → GAP1 → ACK2 → GAP2 → ACK3 → DONE.
  - byte1 is checked against 8'hCD; `opcode_err` = (byte1 != 8'hCD).
  - `vector` = {byte3, byte2}.
- Byte capture: `data_bus` is sampled on the edge that ends each pulse, i.e. the last `int_ack`-high cycle.
- DONE: `vector_valid`=1 and `vector` is held stable.
  - A cycle with `vector_valid & vector_ready` returns the FSM to IDLE and clears `vector_valid`.
- Once started, a sequence always completes:
  - `INT` or `cpu_int_enable` falling mid-sequence is ignored.
  - The PIC returns its spurious vector in that case, and the block passes it through.
- `vector_ready` is ignored outside DONE.
- `INT` is not sampled in DONE. A new sequence can start no earlier than the first IDLE cycle after the handshake.
- Asynchronous reset mid-sequence: `int_ack` drops immediately and all outputs take their reset values. No partial vector is ever presented.

## Timing
- Start latency: `int_ack` rises after the edge that samples the start condition (1 cycle).
- `vector_valid` rises N·PULSE_WIDTH + (N−1)·GAP_WIDTH cycles after the start edge. This coincides with the falling edge of the last pulse.
- Handshake: `vector_valid` falls one edge after the `vector_ready` cycle.
- Back-to-back acknowledges: the earliest next `int_ack` rise is 2 edges after the handshake edge.
- All outputs are registered; no output is combinational from any input.

## Configuration
- `INTACK_8080_MODE_EN` defined:
  - the `mode_8080` and `opcode_err` ports exist;
  - GAP2/ACK3 exist;
  - `mode_8080`=1 runs the 3-pulse sequence;
  - `mode_8080` is sampled only in IDLE at the start of a sequence.
- Not defined:
  - those ports and states are absent;
  - only the 8086 2-pulse sequence exists;
  - `vector[15:8]` is always 8'h00.

## Test plan
- Reset, then `INT`=1 with `cpu_int_enable`=0 for 20 cycles → `int_ack` stays 0 and `busy`=0.
- 8086 mode, defaults, `data_bus`=8'h4B during pulse 2 → `int_ack` high for 2, low for 2, high for 2; `vector_valid` 6 cycles after the start edge; `vector`=16'h004B.
- `vector_ready` held low for 10 cycles in DONE while `INT` is still high → `vector` is held and no new pulse occurs. Raise `vector_ready` for 1 cycle → `vector_valid` clears and the next `int_ack` rises 2 edges after the handshake.
- 8080 mode (macro on), bytes 8'hCD / 8'h34 / 8'h12 → three pulses; `vector`=16'h1234; `opcode_err`=0. Repeat with first byte 8'h00 → `opcode_err`=1.
- `INT` dropped after ACK1 → the sequence completes and `vector` = the byte sampled in pulse 2.
- `reset_n` asserted during GAP1 → `int_ack`=0 immediately and all outputs at reset values. After release, a new sequence starts cleanly from ACK1.
